// File: rtl/lbmem_param.sv
// Line-buffer memory: collects LINE words, then streams each new write out
// with the word written LINE-1 writes earlier; flush (or idle, with AUTO_DRAIN) empties it.
module lbmem_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 64,
  parameter int LINE       = 8,
  parameter int AUTO_DRAIN = 0,
  parameter int LW         = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [LW-1:0]    level,
  output logic             drop,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [LW-1:0] LAST = LW'(LINE - 1);

  state_t              state, state_nxt;
  logic [LW-1:0]       waddr;
  logic [LW-1:0]       level_nxt;
  logic [LW-1:0]       rptr;
  logic                accept;
  logic                pop;
  logic [WIDTH-1:0]    mem [DEPTH];

  // The read side is implied by the write pointer and the fill level.
  assign rptr      = waddr - level;
  assign rdata     = mem[rptr];
  assign dbg_state = state;

  // Handshake: there is no back-pressure. A write is taken when wen=1 and
  // drop=0 in the same cycle; a word is delivered exactly when valid=1.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    accept    = 1'b0;
    pop       = 1'b0;
    unique case (state)
      FILL: begin
        if (flush) begin
          if (level != '0) state_nxt = DRAIN;
        end else if (wen) begin
          accept = 1'b1;
          if (level == LAST) begin
            pop       = 1'b1;
            state_nxt = STREAM;
          end else begin
            level_nxt = level + 1'b1;
          end
        end
      end
      STREAM: begin
        if (flush) begin
          state_nxt = DRAIN;
        end else if (wen) begin
          accept = 1'b1;
          pop    = 1'b1;
        end else if (AUTO_DRAIN != 0) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        pop       = 1'b1;
        level_nxt = level - 1'b1;
        if (level <= LW'(1)) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Gated by reset so both flags read low while RESETN is held, clock or not.
  assign valid = RESETN & pop;
  assign drop  = RESETN & wen & (flush | (state == DRAIN));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= FILL;
      waddr <= '0;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      if (accept) waddr <= waddr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_lbmem_param.sv
// Bench for lbmem_param: one instance per AUTO_DRAIN setting, shared stimulus,
// each compared every cycle against a queue-based model of the line buffer.
module tb_lbmem_param;

  localparam int W    = 8;
  localparam int D    = 64;
  localparam int LINE = 8;

  logic         CLK;
  logic         RESETN;
  logic [W-1:0] wdata;
  logic         wen;
  logic         flush;

  logic [W-1:0] rdata0, rdata1;
  logic         valid0, valid1;
  logic [5:0]   level0, level1;
  logic         drop0, drop1;
  logic [1:0]   state0, state1;

  int checks   = 0;
  int failures = 0;

  // model: stored words per instance and phase (0 fill, 1 stream, 2 drain)
  logic [W-1:0] exp_q [2][$];
  int           mode [2];

  lbmem_param #(.WIDTH(W), .DEPTH(D), .LINE(LINE), .AUTO_DRAIN(0)) dut0 (
    .CLK(CLK), .RESETN(RESETN), .wdata(wdata), .wen(wen), .flush(flush),
    .rdata(rdata0), .valid(valid0), .level(level0), .drop(drop0),
    .dbg_state(state0)
  );

  lbmem_param #(.WIDTH(W), .DEPTH(D), .LINE(LINE), .AUTO_DRAIN(1)) dut1 (
    .CLK(CLK), .RESETN(RESETN), .wdata(wdata), .wen(wen), .flush(flush),
    .rdata(rdata1), .valid(valid1), .level(level1), .drop(drop1),
    .dbg_state(state1)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // compare one instance against the model, then advance the model
  task automatic model_step(input int k);
    logic         e_valid, e_drop;
    logic [W-1:0] e_rdata;
    logic [5:0]   e_level;
    logic [1:0]   e_state;
    string        pfx;
    pfx     = (k == 0) ? "d0" : "d1";
    e_drop  = wen && (flush || mode[k] == 2);
    e_level = 6'(exp_q[k].size());
    e_state = 2'(mode[k]);
    e_valid = 1'b0;
    e_rdata = '0;
    if (mode[k] == 2) begin
      e_valid = 1'b1;
      e_rdata = exp_q[k].pop_front();
      if (exp_q[k].size() == 0) mode[k] = 0;
    end else if (flush) begin
      if (exp_q[k].size() > 0) mode[k] = 2;
    end else if (wen) begin
      exp_q[k].push_back(wdata);
      if (exp_q[k].size() == LINE) begin
        e_valid = 1'b1;
        e_rdata = exp_q[k].pop_front();
        mode[k] = 1;
      end
    end else if (mode[k] == 1 && k == 1) begin
      mode[k] = 2;
    end
    check({pfx, "_state"}, (k == 0) ? state0 : state1, e_state);
    check({pfx, "_level"}, (k == 0) ? level0 : level1, e_level);
    check({pfx, "_drop"},  (k == 0) ? drop0  : drop1,  e_drop);
    check({pfx, "_valid"}, (k == 0) ? valid0 : valid1, e_valid);
    if (e_valid) check({pfx, "_rdata"}, (k == 0) ? rdata0 : rdata1, e_rdata);
  endtask

  // inputs are set just after a rising edge; outputs compared on the falling edge
  task automatic step();
    @(negedge CLK);
    model_step(0);
    model_step(1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic f, input logic [W-1:0] d);
    wen   = w;
    flush = f;
    wdata = d;
    step();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      mode[k] = 0;
    end
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    @(negedge CLK);
    #2;
    wen    = 1'b1;
    flush  = 1'b1;
    RESETN = 1'b0;
    #1;
    check("rst_valid0", valid0, 1'b0);
    check("rst_level0", level0, 6'd0);
    check("rst_drop0",  drop0,  1'b0);
    check("rst_state0", state0, 2'd0);
    check("rst_valid1", valid1, 1'b0);
    check("rst_level1", level1, 6'd0);
    model_reset();
    wen   = 1'b0;
    flush = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int waited;
    RESETN = 1'b0;
    wen    = 1'b0;
    flush  = 1'b0;
    wdata  = '0;
    model_reset();
    #12;
    check("init_valid", valid0, 1'b0);
    check("init_level", level0, 6'd0);
    check("init_state", state0, 2'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // fill then stream
    for (int i = 1; i <= 20; i++) drive(1'b1, 1'b0, 8'(i));
    // idle: dut1 auto-drains, with one write pulse landing in its drain
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd99);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 8'd0);
    // flush with write in the same cycle, then let it drain
    drive(1'b1, 1'b1, 8'd77);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b0, 8'd0);
    // flush while empty has no effect
    drive(1'b1, 1'b1, 8'd55);
    // long run across both pointer wraps
    for (int i = 0; i < 150; i++) drive(1'b1, 1'b0, 8'(i));
    // reset in the middle of a drain at level 4
    drive(1'b0, 1'b1, 8'd0);
    waited = 0;
    while (exp_q[0].size() != 4 && waited < 20) begin
      drive(1'b0, 1'b0, 8'd0);
      waited++;
    end
    check("drain_reached_4", level0, 6'd4);
    async_reset();
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(i));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            8'($urandom_range(0, 255)));
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    drive(1'b0, 1'b0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbmem_param.md
LBMEM_PARAM -- requirements
Module: lbmem_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 64: storage entries; SHALL be a power of 2, at least 4.
REQ-003 Parameter LINE, default 8: window length in words; SHALL satisfy 2 <= LINE <= DEPTH-1.
REQ-004 Parameter AUTO_DRAIN, default 0: 1 means STREAM with wen low starts a drain.
REQ-005 Parameter LW = clog2(DEPTH), derived: width of level and of the address pointers.
REQ-006 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-007 RESETN  input  1  asynchronous, active-low reset.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 wen  input  1  write request.
REQ-010 flush  input  1  request to drain the stored words.
REQ-011 rdata  output  WIDTH  oldest stored word; don't-care while valid=0.
REQ-012 valid  output  1  rdata is a consumed output word this cycle.
REQ-013 level  output  LW  count of stored, unconsumed words.
REQ-014 drop  output  1  wdata discarded this cycle.

Function
REQ-015 Storage SHALL be a DEPTH x WIDTH array written at waddr; waddr increments mod DEPTH on every accepted write.
REQ-016 Read pointer SHALL be rptr = (waddr - level) mod DEPTH in LW-bit arithmetic; rdata = mem[rptr], combinational.
REQ-017 The write pointer wraps from DEPTH-1 to 0 with no gap, and the read pointer is derived from it.
REQ-018 The FSM SHALL have three states: FILL, STREAM, DRAIN.
REQ-019 FILL, wen=1, flush=0, level<LINE-1: accept the write; level+1; valid=0.
REQ-020 FILL, wen=1, flush=0, level==LINE-1: accept the write; valid=1 with the oldest word; level unchanged; next state STREAM.
REQ-021 STREAM, wen=1, flush=0: accept the write; valid=1 with the oldest word; level stays LINE-1 (push and pop together).
REQ-022 STREAM, wen=0, flush=0, AUTO_DRAIN=0: hold all state; valid=0.
REQ-023 STREAM, wen=0, flush=0, AUTO_DRAIN=1: valid=0 this cycle; next state DRAIN.
REQ-024 flush=1 in FILL with level>0, or in STREAM: valid=0; no write; next state DRAIN.
REQ-025 flush=1 in FILL with level==0: no effect; state stays FILL.
REQ-026 DRAIN, every cycle: valid=1 with the oldest word; level-1; when level goes 1->0, next state FILL.
REQ-027 DRAIN: flush is ignored, and wen is not accepted (waddr and memory unchanged).
REQ-028 drop SHALL equal wen AND (flush OR state==DRAIN), combinational.
REQ-029 When flush and wen are high together, flush wins: no write and drop=1.
REQ-030 level SHALL never exceed LINE-1, so overflow cannot occur.
REQ-031 valid SHALL be combinational from state, level, wen and flush, with no added latency.

Reset
REQ-032 RESETN low SHALL immediately force state=FILL, waddr=0, level=0, valid=0, drop=0, regardless of CLK.
REQ-033 Memory contents are not reset; operation resumes on the first CLK edge after RESETN rises.
REQ-034 Reset asserted mid-STREAM or mid-DRAIN SHALL discard all stored words, with no output.

Verification (WIDTH=8, DEPTH=64, LINE=8)
REQ-035 Write 1..8 on consecutive cycles -> valid=0 for words 1-7; on the 8th write valid=1, rdata=1; then level=7, state STREAM.
REQ-036 Continue writing 9..20 -> each cycle valid=1 and rdata = wdata-7; level stays 7.
REQ-037 After 8 writes, pulse flush with wen=1 -> drop=1 and valid=0 that cycle; then 7 cycles of valid=1 with rdata 2..8; then level=0, state FILL.
REQ-038 Write 0..149 continuously -> for every write from the 8th on, rdata = wdata-7 across both waddr wraps at 64.
REQ-039 AUTO_DRAIN=1: write 1..10, then wen=0 -> one cycle valid=0; then 7 cycles rdata 4..10; wen pulsed during DRAIN -> drop=1 and level unaffected.
REQ-040 RESETN low mid-DRAIN (level=4) -> valid=0 and level=0 with no clock edge; the next 8 writes repeat the REQ-035 behaviour.
